// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RISC controller.
//   - opcode map of the instruction set
//   - 3-bit FSM state encoding
//   - instruction-class enum produced by ctrl_decode
//   - branch-condition codes and the flag test that resolves them
package ctrl_pkg;

  localparam logic [4:0] OP_RR    = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUBI  = 5'b00010;
  localparam logic [4:0] OP_MOV   = 5'b00011;
  localparam logic [4:0] OP_LHI   = 5'b00100;
  localparam logic [4:0] OP_LLI   = 5'b00101;
  localparam logic [4:0] OP_LDRRI = 5'b00110;
  localparam logic [4:0] OP_LDRRR = 5'b00111;
  localparam logic [4:0] OP_STRRI = 5'b01000;
  localparam logic [4:0] OP_STRRR = 5'b01001;
  localparam logic [4:0] OP_OUTR  = 5'b01010;
  localparam logic [4:0] OP_HLT   = 5'b01011;
  localparam logic [4:0] OP_BCC   = 5'b11000;
  localparam logic [4:0] OP_BCS   = 5'b11001;
  localparam logic [4:0] OP_BNE   = 5'b11010;
  localparam logic [4:0] OP_BEQ   = 5'b11011;
  localparam logic [4:0] OP_BAL   = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_RR, CL_IMM, CL_LI, CL_MOV, CL_LD, CL_ST, CL_BR, CL_OUT, CL_HLT, CL_ILL
  } instr_class_e;

  typedef enum logic [2:0] {
    BC_NONE, BC_CC, BC_CS, BC_NE, BC_EQ, BC_AL
  } br_cond_e;

  // zc = {Z,C}. BAL is "always" but the PC+1 path is what the datapath
  // expects for it, so it never asserts Branch.
  function automatic logic br_taken(br_cond_e cond, logic [1:0] zc);
    logic taken;
    taken = 1'b0;
    case (cond)
      BC_CC:   taken = ~zc[0];
      BC_CS:   taken =  zc[0];
      BC_NE:   taken = ~zc[1];
      BC_EQ:   taken =  zc[1];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decode.
//   opcode    in  5  instruction opcode
//   ALUopcode in  2  RR function select (bit0 = with carry, bit1 = subtract)
//   cls       out    instruction class
//   is_lhi    out 1  distinguishes LHI from LLI inside the LI class
//   alu_carry out 1  ALU uses carry-in (ADC/SBB)
//   alu_sub   out 1  ALU subtracts (SUB/SBB/SUBI)
//   br_cond   out    branch condition for the branch class
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  input  logic [1:0]   ALUopcode,
  output instr_class_e cls,
  output logic         is_lhi,
  output logic         alu_carry,
  output logic         alu_sub,
  output br_cond_e     br_cond
);

  always_comb begin
    cls       = CL_ILL;
    is_lhi    = 1'b0;
    alu_carry = 1'b0;
    alu_sub   = 1'b0;
    br_cond   = BC_NONE;
    case (opcode)
      OP_RR: begin
        cls       = CL_RR;
        alu_carry = ALUopcode[0];
        alu_sub   = ALUopcode[1];
      end
      OP_ADDI:  cls = CL_IMM;
      OP_SUBI: begin
        cls     = CL_IMM;
        alu_sub = 1'b1;
      end
      OP_MOV:   cls = CL_MOV;
      OP_LHI: begin
        cls    = CL_LI;
        is_lhi = 1'b1;
      end
      OP_LLI:   cls = CL_LI;
      OP_LDRRI, OP_LDRRR: cls = CL_LD;
      OP_STRRI, OP_STRRR: cls = CL_ST;
      OP_OUTR:  cls = CL_OUT;
      OP_HLT:   cls = CL_HLT;
      OP_BCC: begin cls = CL_BR; br_cond = BC_CC; end
      OP_BCS: begin cls = CL_BR; br_cond = BC_CS; end
      OP_BNE: begin cls = CL_BR; br_cond = BC_NE; end
      OP_BEQ: begin cls = CL_BR; br_cond = BC_EQ; end
      OP_BAL: begin cls = CL_BR; br_cond = BC_AL; end
      default:  cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM that sequences the multicycle RISC datapath.
// Branch/OutR/HLT/NOP take 2 cycles, stores 4, ALU/load/immediate ops 5.
// Waits in IDLE until start (or leaves at once when AUTO_START=1) so that
// memory can be preloaded first. HALT is only left through Rst.
//
// Ports:
//   clk, Rst (async, active-high), start (pulse, only honoured in IDLE)
//   opcode[4:0], ALUopcode[1:0], PSW_NZC[2:0] = {N,Z,C} from the datapath
//   memory-stage : ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns
//   register file: WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF
//   ALU          : Flag, ALUop, Buff_PSW
//   PC           : Branch, Jump[1:0] (reserved, always 0), Buff_PC
//   status       : done (HALT), busy (not IDLE and not HALT)
//
// Build option: define CTRL_PERF_CNT_EN to add instr_cnt[15:0] (retired
// instructions, one per Buff_PC pulse) and cycle_cnt[15:0] (busy cycles).
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit AUTO_START = 1'b0
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [1:0] ALUopcode,
  input  logic [2:0] PSW_NZC,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       MEMresource,
  output logic       WE_MEM,
  output logic       Buff_MEMIns,
  output logic       WBresource,
  output logic       RBresource,
  output logic       oprandB,
  output logic       LI,
  output logic       PCplus1orWB,
  output logic       WE_RF,
  output logic       Flag,
  output logic       ALUop,
  output logic       Buff_PSW,
  output logic       Branch,
  output logic [1:0] Jump,
  output logic       Buff_PC,
  output logic       done,
  output logic       busy
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0] instr_cnt,
  output logic [15:0] cycle_cnt
`endif
);

  state_e       state, state_nxt;
  instr_class_e cls;
  br_cond_e     br_cond;
  logic         is_lhi, alu_carry, alu_sub;

  // N is not used by any branch condition of this instruction set.
  logic unused_n;
  assign unused_n = PSW_NZC[2];

  assign Jump = 2'b00;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .ALUopcode (ALUopcode),
    .cls       (cls),
    .is_lhi    (is_lhi),
    .alu_carry (alu_carry),
    .alu_sub   (alu_sub),
    .br_cond   (br_cond)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode the registered state (plus the stable instruction
  // buffer), so an asynchronous reset forces every control low at once.
  always_comb begin
    state_nxt   = state;
    ALUorNot    = 1'b0;
    LIorMOV     = 1'b0;
    MEMresource = 1'b0;
    WE_MEM      = 1'b0;
    Buff_MEMIns = 1'b0;
    WBresource  = 1'b0;
    RBresource  = 1'b0;
    oprandB     = 1'b0;
    LI          = 1'b0;
    PCplus1orWB = 1'b0;
    WE_RF       = 1'b0;
    Flag        = 1'b0;
    ALUop       = 1'b0;
    Buff_PSW    = 1'b0;
    Branch      = 1'b0;
    Buff_PC     = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || AUTO_START) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy        = 1'b1;
        Buff_MEMIns = 1'b1;
        state_nxt   = ST_DECODE;
      end
      ST_DECODE: begin
        busy      = 1'b1;
        state_nxt = ST_EXEC;
        case (cls)
          CL_LI: begin
            LI         = is_lhi;
            RBresource = is_lhi;
          end
          CL_IMM: oprandB = 1'b1;
          CL_BR: begin
            Buff_PC   = 1'b1;
            Branch    = br_taken(br_cond, PSW_NZC[1:0]);
            state_nxt = ST_FETCH;
          end
          CL_OUT, CL_ILL: begin
            Buff_PC   = 1'b1;
            state_nxt = ST_FETCH;
          end
          CL_HLT: begin
            Buff_PC   = 1'b1;
            state_nxt = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        busy      = 1'b1;
        state_nxt = ST_MEM;
        case (cls)
          CL_RR, CL_IMM: begin
            Flag     = alu_carry;
            ALUop    = alu_sub;
            Buff_PSW = 1'b1;
          end
          // Address calculation is a plain add with PSW left untouched.
          CL_ST: RBresource = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        busy      = 1'b1;
        state_nxt = ST_WB;
        case (cls)
          CL_LI:  ALUorNot = 1'b1;
          CL_MOV: begin
            ALUorNot = 1'b1;
            LIorMOV  = 1'b1;
          end
          CL_LD:  MEMresource = 1'b1;
          CL_ST: begin
            MEMresource = 1'b1;
            WE_MEM      = 1'b1;
            Buff_PC     = 1'b1;
            state_nxt   = ST_FETCH;
          end
          default: ;
        endcase
      end
      ST_WB: begin
        busy        = 1'b1;
        WE_RF       = 1'b1;
        PCplus1orWB = 1'b1;
        Buff_PC     = 1'b1;
        WBresource  = (cls == CL_LD);
        state_nxt   = ST_FETCH;
      end
      ST_HALT: begin
        done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // Buff_PC and busy are both low in HALT, so the counters freeze there;
  // the explicit state test keeps that true if the decode ever changes.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      instr_cnt <= 16'd0;
      cycle_cnt <= 16'd0;
    end else if (state != ST_HALT) begin
      if (Buff_PC) instr_cnt <= instr_cnt + 16'd1;
      if (busy)    cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM controller for the multicycle RISC Datapath.
- Each cycle it decodes opcode/ALUopcode from the datapath's instruction buffer and PSW_NZC flags, and drives the full Datapath control bundle: 2-cycle branch/OutR/HLT/NOP, 4-cycle store, 5-cycle ALU/load/immediate instructions.
- Sits beside Datapath in the CPU top and replaces bench-driven control; it waits in IDLE until start, so memory can be preloaded through the TB port.

Parameters:
- AUTO_START, 0, 1 = leave IDLE on the first cycle after reset without needing start.

Ports:
- clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; IDLE -> FETCH
- opcode  in  5  from Datapath instruction buffer
- ALUopcode  in  2  from Datapath; selects the RR ALU function
- PSW_NZC  in  3  {N,Z,C} from Datapath PSW
- ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns  out  1 each  memory-stage controls
- WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF  out  1 each  register-file controls
- Flag, ALUop, Buff_PSW  out  1 each  ALU controls
- Branch  out  1  PC branch control
- Jump  out  2  PC jump select; held at 2'b00 (reserved)
- Buff_PC  out  1  PC update strobe
- done  out  1  high while in HALT
- busy  out  1  high in any state except IDLE and HALT

Behaviour:
- Reset: all outputs 0 and state = IDLE, applied asynchronously. Reset mid-instruction aborts immediately with no partial writes.
- Outputs are Moore/registered-state decode. Every don't-care control is driven 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: leave to FETCH when start=1 or AUTO_START=1.
- FETCH: Buff_MEMIns=1, MEMresource=0; next DECODE.
- DECODE:
  - LHI: LI=1, RBresource=1.
  - LLI: LI=0.
  - Immediate ops: oprandB=1.
  - RR ops: RBresource=0, oprandB=0.
  - Branch class: Buff_PC=1, Branch=condition; next FETCH.
  - OutR and illegal opcodes: Buff_PC=1; next FETCH.
  - HLT: Buff_PC=1; next HALT.
  - All other classes: next EXEC.
- EXEC:
  - ADD: Flag=0, ALUop=0, Buff_PSW=1.
  - ADC: Flag=1, ALUop=0, Buff_PSW=1.
  - SUB: Flag=0, ALUop=1, Buff_PSW=1.
  - SBB: Flag=1, ALUop=1, Buff_PSW=1.
  - ADDI/SUBI: same as ADD/SUB.
  - LDR/STR: Flag=0, ALUop=0, Buff_PSW=0 (address calculation). STR also drives RBresource=1.
  - Next MEM.
- MEM:
  - ALU ops: ALUorNot=0.
  - LHI/LLI: ALUorNot=1, LIorMOV=0.
  - MOV: ALUorNot=1, LIorMOV=1.
  - LDR: MEMresource=1.
  - STR: MEMresource=1, WE_MEM=1, Buff_PC=1; next FETCH.
  - All others: next WB.
- WB: WE_RF=1, PCplus1orWB=1, Buff_PC=1; WBresource=1 for LDR, else 0; next FETCH.
- HALT: done=1; held until Rst. start is ignored in every state except IDLE.
- Branch conditions, sampled in DECODE:
  - BCC: ~C. BCS: C.
  - BNE: ~Z. BEQ: Z.
  - BAL: Branch=0 (PC+1 path).
- Opcode map:
  - 00000 RR group (ALUopcode 00 ADD, 01 ADC, 10 SUB, 11 SBB).
  - 00001 ADDI, 00010 SUBI, 00011 MOV, 00100 LHI, 00101 LLI.
  - 00110 LDRri, 00111 LDRrr, 01000 STRri, 01001 STRrr.
  - 01010 OutR, 01011 HLT.
  - 11000 BCC, 11001 BCS, 11010 BNE, 11011 BEQ, 11100 BAL.
  - All other codes are illegal and execute as a NOP.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs instr_cnt[15:0] and cycle_cnt[15:0].
  - instr_cnt increments on each Buff_PC pulse (one per retired instruction).
  - cycle_cnt increments every cycle while busy.
  - Both reset to 0 and wrap at 16'hFFFF -> 0; both freeze in HALT.
- Undefined: neither port nor either counter exists.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - state encoding (3 bits);
  - instruction-class enum (RR, IMM, LI, MOV, LD, ST, BR, OUT, HLT, ILL);
  - branch-condition codes.
- Sub-module ctrl_decode: combinational opcode/ALUopcode -> class plus ALU function bits. The FSM and output decode remain in multicycle_controller.

Test Plan:
- Rst=1 mid-EXEC of an ADD -> all outputs 0 and busy=0 within the same cycle; after release, state remains IDLE until start.
- start, then LLI (00101) -> 5 cycles: Buff_MEMIns=1 in cycle 1; ALUorNot=1, LIorMOV=0 in cycle 4; WE_RF=1, PCplus1orWB=1, Buff_PC=1 in cycle 5.
- RR opcode 00000 with ALUopcode=01 (ADC) -> EXEC cycle shows Flag=1, ALUop=0, Buff_PSW=1; WB cycle shows WBresource=0.
- BCS with PSW_NZC=3'b001 -> DECODE shows Branch=1, Buff_PC=1. Repeat with 3'b000 -> Branch=0. Each takes 2 cycles.
- STRri (01000) -> 4 cycles; MEM cycle shows MEMresource=1, WE_MEM=1, Buff_PC=1; WE_RF=0 throughout.
- HLT (01011) -> Buff_PC=1 in DECODE, then done=1 and busy=0 held for 20 cycles despite start pulses. With CTRL_PERF_CNT_EN, instr_cnt equals the number of executed instructions.
